decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction-decode stage directly downstream of the fetch stage.
- Holds the IF/ID pipeline register and the 32x32 register file. Extracts instruction fields and sign-extends the immediate.
- Detects load-use hazards and drives a stall back to fetch so the PC is held.
- A taken branch (the same PCsrc signal that redirects fetch) flushes the instruction held in ID.

Parameters:
DATA_W, 32, datapath and instruction width
NREGS, 32, register file depth (address width = 5)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
if_inst  in  32  instruction from fetch stage
if_pc_next  in  32  fetch PC+1 (word-addressed) accompanying if_inst
flush  in  1  taken branch/jump (PCsrc); squash ID contents
ex_memread  in  1  instruction currently in EX is a load
ex_rt  in  5  destination register of that load
wb_we  in  1  register file write enable from writeback
wb_addr  in  5  writeback register address
wb_data  in  32  writeback data
stall  out  1  to fetch: hold PC and IF/ID this cycle
id_valid  out  1  ID output holds a real instruction (0 = bubble)
id_opcode  out  6  inst[31:26]
id_rs  out  5  inst[25:21]
id_rt  out  5  inst[20:16]
id_rd  out  5  inst[15:11]
id_imm_ext  out  32  sign-extended inst[15:0]
id_rs_data  out  32  register file read of rs
id_rt_data  out  32  register file read of rt
id_pc_next  out  32  registered if_pc_next

Behaviour:
- Reset (rst_n=0, async):
  - IF/ID instruction register = 0 (NOP); pc_next register = 0; valid flop = 0; primed flop = 0.
  - All 32 registers = 0.
  - Resulting outputs: stall=0, id_valid=0, all fields 0.
- Primed flop:
  - The first rising edge after rst_n deasserts sets primed=1 and does NOT set valid.
  - This discards the duplicated first fetch, which occurs because fetch presents PC 0 for two cycles after reset.
  - From the second edge on, captures follow the normal rules below.
- IF/ID update on each rising edge, in priority order:
  1. flush=1: instruction reg <= 0, valid <= 0. Flush overrides stall.
  2. stall=1: hold all IF/ID contents.
  3. Otherwise: latch if_inst and if_pc_next; valid <= primed.
- Stall (combinational from registered IF/ID fields):
  - stall = valid & ex_memread & (ex_rt != 0) & (ex_rt == rs | ex_rt == rt).
  - A load followed immediately by its consumer therefore costs exactly one bubble cycle.
- id_valid = valid & ~stall. While stalled, a bubble is presented to EX and the instruction stays in ID.
- Field extraction is purely combinational from the IF/ID instruction register (zero latency after capture). id_imm_ext = {16{inst[15]}, inst[15:0]}.
- Register file:
  - Write: on the rising edge when wb_we=1 and wb_addr != 0. Writes to r0 are ignored.
  - Read: combinational. r0 always reads 0.
  - Internal bypass: if wb_we=1 and wb_addr != 0 and wb_addr equals the read address, the read returns wb_data in the same cycle (write-before-read).
- Simultaneous flush and stall: flush wins. Valid is cleared and stall deasserts the next cycle because valid=0.
- Reset mid-operation: all state clears immediately. The primed sequence restarts on the next deassertion.
- Widths are fixed. No arithmetic beyond sign extension; no wrap concerns.

Test Plan:
- Reset, then if_inst=0x8C220004 held for two edges, then 0x00430820 → after edge 1 id_valid=0; after edge 2 id_valid=1, id_opcode=0x23, id_rs=1, id_rt=2, id_imm_ext=0x00000004; after edge 3 id_rd=1.
- Write r5=0xDEADBEEF (wb_we=1, wb_addr=5), and in the same cycle decode an instruction with rs=5 → id_rs_data=0xDEADBEEF that cycle via bypass, and still 0xDEADBEEF on later cycles from storage.
- wb_we=1, wb_addr=0, wb_data=0x12345678, then read r0 → id_rs_data=0.
- ID holds rs=3; ex_memread=1, ex_rt=3 → stall=1, id_valid=0, IF/ID contents unchanged across the edge. Next cycle ex_memread=0 → stall=0, id_valid=1 with the same instruction. Repeat with ex_rt=0 → stall=0.
- Stall condition active while flush=1 → after the edge id_valid=0, instruction reg=0, stall=0.
- Assert rst_n=0 mid-stream between edges → outputs clear immediately without a clock. After release, the first captured instruction is again discarded (id_valid=0 after the first edge).

Source files
------------

// File: rtl/decode_stage.sv
// Instruction-decode stage: IF/ID pipeline register, 32x32 register file with
// write-before-read bypass, field extraction and load-use stall generation.
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] if_inst,
    input  logic [DATA_W-1:0] if_pc_next,
    input  logic              flush,
    input  logic              ex_memread,
    input  logic [4:0]        ex_rt,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              id_valid,
    output logic [5:0]        id_opcode,
    output logic [4:0]        id_rs,
    output logic [4:0]        id_rt,
    output logic [4:0]        id_rd,
    output logic [DATA_W-1:0] id_imm_ext,
    output logic [DATA_W-1:0] id_rs_data,
    output logic [DATA_W-1:0] id_rt_data,
    output logic [DATA_W-1:0] id_pc_next
);

    localparam int ADDR_W = $clog2(NREGS);

    logic [DATA_W-1:0] inst_reg;
    logic [DATA_W-1:0] pc_next_reg;
    logic              valid_reg;
    logic              primed_reg;

    logic [DATA_W-1:0] rf_reg [1:NREGS-1];
    logic              wb_hit;
    logic              stall_next;
    logic [DATA_W-1:0] rs_data_next;
    logic [DATA_W-1:0] rt_data_next;

    // ------------------------------------------------------------------
    // Field extraction straight off the IF/ID register
    // ------------------------------------------------------------------
    assign id_opcode  = inst_reg[31:26];
    assign id_rs      = inst_reg[25:21];
    assign id_rt      = inst_reg[20:16];
    assign id_rd      = inst_reg[15:11];
    assign id_imm_ext = {{(DATA_W-16){inst_reg[15]}}, inst_reg[15:0]};
    assign id_pc_next = pc_next_reg;

    // ------------------------------------------------------------------
    // Load-use hazard: the consumer waits one cycle in ID
    // ------------------------------------------------------------------
    always_comb begin
        stall_next = 1'b0;
        if (valid_reg && ex_memread && (ex_rt != 5'd0) &&
            ((ex_rt == id_rs) || (ex_rt == id_rt)))
            stall_next = 1'b1;
    end

    assign stall    = stall_next;
    assign id_valid = valid_reg & ~stall_next;

    // ------------------------------------------------------------------
    // IF/ID register; the first edge after reset only primes, discarding
    // the duplicated PC-0 fetch.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_reg    <= '0;
            pc_next_reg <= '0;
            valid_reg   <= 1'b0;
            primed_reg  <= 1'b0;
        end else begin
            primed_reg <= 1'b1;
            if (flush) begin
                inst_reg  <= '0;
                valid_reg <= 1'b0;
            end else if (!stall_next) begin
                inst_reg    <= if_inst;
                pc_next_reg <= if_pc_next;
                valid_reg   <= primed_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file; r0 has no storage and reads as zero
    // ------------------------------------------------------------------
    assign wb_hit = wb_we && (wb_addr != 5'd0);

    for (genvar gi = 1; gi < NREGS; gi++) begin : g_rf
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                rf_reg[gi] <= '0;
            else if (wb_hit && (wb_addr == ADDR_W'(gi)))
                rf_reg[gi] <= wb_data;
        end
    end

    // Reads see a same-cycle writeback (write-before-read)
    always_comb begin
        rs_data_next = '0;
        for (int i = 1; i < NREGS; i++)
            if (id_rs == ADDR_W'(i))
                rs_data_next = rf_reg[i];
        if (wb_hit && (wb_addr == id_rs))
            rs_data_next = wb_data;
    end

    always_comb begin
        rt_data_next = '0;
        for (int i = 1; i < NREGS; i++)
            if (id_rt == ADDR_W'(i))
                rt_data_next = rf_reg[i];
        if (wb_hit && (wb_addr == id_rt))
            rt_data_next = wb_data;
    end

    assign id_rs_data = rs_data_next;
    assign id_rt_data = rt_data_next;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference model predicts each cycle's
// outputs into a queue, a negedge monitor pops and compares.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_inst, if_pc_next;
    logic        flush, ex_memread;
    logic [4:0]  ex_rt;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall, id_valid;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_imm_ext, id_rs_data, id_rt_data, id_pc_next;

    decode_stage #(.DATA_W(32), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .if_inst(if_inst), .if_pc_next(if_pc_next),
        .flush(flush), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall(stall), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm_ext(id_imm_ext),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_pc_next(id_pc_next)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        valid;
        logic [5:0]  opcode;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm, rs_data, rt_data, pc;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0;
    int   nmis = 0;
    int   ntxn = 0;

    // Reference model state: what instruction sits in ID and the architectural registers
    logic [31:0] m_inst, m_pc;
    bit          m_valid, m_primed;
    logic [31:0] m_rf [32];

    task automatic model_reset();
        m_inst = 0; m_pc = 0; m_valid = 0; m_primed = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return m_rf[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL txn %0d %s: got %h expected %h", ntxn, name, act, exp);
        end
    endtask

    // One clock of stimulus: predict this cycle's outputs, then advance the model
    task automatic step();
        exp_t e;
        logic [4:0] rs, rt;
        bit hz;
        if (!rst_n) model_reset();
        rs = m_inst[25:21];
        rt = m_inst[20:16];
        hz = m_valid && ex_memread && (ex_rt != 0) && (ex_rt == rs || ex_rt == rt);
        e.stall   = hz;
        e.valid   = m_valid && !hz;
        e.opcode  = m_inst[31:26];
        e.rs      = rs;
        e.rt      = rt;
        e.rd      = m_inst[15:11];
        e.imm     = 32'($signed(m_inst[15:0]));
        e.rs_data = m_read(rs);
        e.rt_data = m_read(rt);
        e.pc      = m_pc;
        exp_q.push_back(e);
        @(posedge clk);
        if (rst_n) begin
            if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_data;
            if (flush) begin
                m_inst  = 0;
                m_valid = 0;
            end else if (!hz) begin
                m_inst  = if_inst;
                m_pc    = if_pc_next;
                m_valid = m_primed;
            end
            m_primed = 1;
        end
        #1;
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ntxn++;
            $display("txn %0d: rst_n=%b valid=%b stall=%b op=%h rs=%0d rt=%0d rd=%0d imm=%h rsd=%h rtd=%h pc=%h",
                     ntxn, rst_n, id_valid, stall, id_opcode, id_rs, id_rt, id_rd,
                     id_imm_ext, id_rs_data, id_rt_data, id_pc_next);
            chk("stall",   32'(stall),     32'(e.stall));
            chk("valid",   32'(id_valid),  32'(e.valid));
            chk("opcode",  32'(id_opcode), 32'(e.opcode));
            chk("rs",      32'(id_rs),     32'(e.rs));
            chk("rt",      32'(id_rt),     32'(e.rt));
            chk("rd",      32'(id_rd),     32'(e.rd));
            chk("imm_ext", id_imm_ext,     e.imm);
            chk("rs_data", id_rs_data,     e.rs_data);
            chk("rt_data", id_rt_data,     e.rt_data);
            chk("pc_next", id_pc_next,     e.pc);
        end
    end

    task automatic idle_inputs();
        flush = 0; ex_memread = 0; ex_rt = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    endtask

    initial begin
        rst_n = 0; if_inst = 0; if_pc_next = 0;
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        step();                                   // held in reset
        rst_n = 1;

        // Duplicated first fetch, then a load and an add
        if_inst = 32'h8C220004; if_pc_next = 32'd1; step();
        step();
        if_inst = 32'h00430820; if_pc_next = 32'd2; step();

        // Bypass into rs=5, then read back from storage
        if_inst = 32'h00A63000; if_pc_next = 32'd3; step();
        wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; step();
        wb_we = 0; step();
        step();

        // Writes to r0 are dropped
        if_inst = 32'h00004800; if_pc_next = 32'd4;
        wb_we = 1; wb_addr = 0; wb_data = 32'h12345678; step();
        wb_we = 0; step();

        // Load-use stall on rs=3, release, then ex_rt=0 never stalls
        if_inst = 32'h0064F800; if_pc_next = 32'd5; step();
        if_inst = 32'h8FFF8000; if_pc_next = 32'd6;
        ex_memread = 1; ex_rt = 3; step();
        ex_memread = 0; step();
        if_inst = 32'h0000FFFF; if_pc_next = 32'd7; step();
        ex_memread = 1; ex_rt = 0; step();
        idle_inputs();

        // Flush wins over an active stall
        if_inst = 32'h00640000; if_pc_next = 32'd8; step();
        ex_memread = 1; ex_rt = 3; flush = 1; step();
        idle_inputs(); step();

        // Asynchronous reset mid-cycle, then the prime sequence again
        if_inst = 32'h8C220004; if_pc_next = 32'd9; step();
        rst_n = 0; step();
        rst_n = 1; step();
        step();
        step();

        // Randomized traffic with small register indices so hazards and bypasses collide
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            r = $urandom;
            r[25:21] = 5'($urandom_range(0, 7));
            r[20:16] = 5'($urandom_range(0, 7));
            if_inst    = r;
            if_pc_next = $urandom;
            rst_n      = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            flush      = ($urandom_range(0, 9) == 0);
            ex_memread = ($urandom_range(0, 9) < 4);
            ex_rt      = 5'($urandom_range(0, 7));
            wb_we      = ($urandom_range(0, 1) == 1);
            wb_addr    = 5'($urandom_range(0, 7));
            wb_data    = $urandom;
            step();
        end

        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete (got running, expected finished)");
        $fatal(1, "timeout");
    end

endmodule
